// File: rtl/systolic_matmul_engine_pkg.sv
// Shared types and helpers for the output-stationary systolic matrix-multiply engine.
// Holds the job FSM state encoding, the flush length and the product-extension helper.
package systolic_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        FLUSH = 2'd2,
        DRAIN = 2'd3
    } state_e;

    // Widest product/accumulator the extension helper supports.
    localparam int MAX_EXT_W = 64;

    // Enabled edges the last k-slice needs to reach the far corner PE's accumulator.
    function automatic int flush_cycles(input int n);
        return 2 * n - 1;
    endfunction

    // Extends a w-bit product to MAX_EXT_W bits, sign-filling only in signed mode.
    function automatic logic [MAX_EXT_W-1:0] ext_product(
        input logic [MAX_EXT_W-1:0] p,
        input int                   w,
        input logic                 sgn
    );
        logic [MAX_EXT_W-1:0] r;
        logic                 fill;
        fill = sgn & p[w-1];
        for (int b = 0; b < MAX_EXT_W; b++) begin
            r[b] = (b < w) ? p[b] : fill;
        end
        return r;
    endfunction

endpackage

// File: rtl/systolic_matmul_engine_if.sv
// Job control, operand stream and result stream of the systolic matmul engine.
// Both streams use valid/ready: a beat transfers on the edge where valid && ready; valid holds its payload until then.
interface systolic_matmul_engine_if #(
    parameter int N         = 16,
    parameter int OP_WIDTH  = 8,
    parameter int ACC_WIDTH = 32,
    parameter int K_WIDTH   = 16
);
    import systolic_pkg::*;

    logic                   start;
    logic                   signed_mode;
    logic [K_WIDTH-1:0]     k_len;
    logic                   in_valid;
    logic                   in_ready;
    logic [N*OP_WIDTH-1:0]  a_col;
    logic [N*OP_WIDTH-1:0]  b_row;
    logic                   busy;
    logic                   out_valid;
    logic                   out_ready;
    logic [N*ACC_WIDTH-1:0] out_row;
    logic [$clog2(N)-1:0]   out_row_idx;
    logic                   done;
    state_e                 dbg_state;

    modport master (
        output start, signed_mode, k_len, in_valid, a_col, b_row, out_ready,
        input  in_ready, busy, out_valid, out_row, out_row_idx, done, dbg_state
    );

    modport slave (
        input  start, signed_mode, k_len, in_valid, a_col, b_row, out_ready,
        output in_ready, busy, out_valid, out_row, out_row_idx, done, dbg_state
    );

endinterface

// File: rtl/systolic_matmul_engine_mac_pe.sv
// One processing element: registers the A/B operands it forwards to its neighbours
// and accumulates the product of the pair it currently holds on each enabled edge.
module mac_pe
    import systolic_pkg::*;
#(
    parameter int OP_WIDTH  = 8,
    parameter int ACC_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en_i,
    input  logic                 clr_i,
    input  logic                 signed_i,
    input  logic [OP_WIDTH-1:0]  a_i,
    input  logic [OP_WIDTH-1:0]  b_i,
    output logic [OP_WIDTH-1:0]  a_o,
    output logic [OP_WIDTH-1:0]  b_o,
    output logic [ACC_WIDTH-1:0] acc_o
);

    logic [OP_WIDTH-1:0]   a_q, b_q;
    logic [ACC_WIDTH-1:0]  acc_q, acc_d;
    logic [2*OP_WIDTH-1:0] prod_u, prod_s, prod;

    // Low 2*OP_WIDTH bits differ between signed and unsigned products, so both are formed.
    assign prod_u = {{OP_WIDTH{1'b0}}, a_q} * {{OP_WIDTH{1'b0}}, b_q};
    assign prod_s = {{OP_WIDTH{a_q[OP_WIDTH-1]}}, a_q} * {{OP_WIDTH{b_q[OP_WIDTH-1]}}, b_q};
    assign prod   = signed_i ? prod_s : prod_u;

    assign acc_d = acc_q + ACC_WIDTH'(ext_product(MAX_EXT_W'(prod), 2 * OP_WIDTH, signed_i));

    always_ff @(posedge clk) begin
        if (reset || clr_i) begin
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
        end else if (en_i) begin
            a_q   <= a_i;
            b_q   <= b_i;
            acc_q <= acc_d;
        end
    end

    assign a_o   = a_q;
    assign b_o   = b_q;
    assign acc_o = acc_q;

endmodule

// File: rtl/systolic_matmul_engine.sv
// Output-stationary NxN systolic engine computing C = A*B with run-time K.
// Holds the job FSM, the operand skew chains, the PE grid and the row drain mux.
module systolic_matmul_engine
    import systolic_pkg::*;
#(
    parameter int N         = 16,
    parameter int OP_WIDTH  = 8,
    parameter int ACC_WIDTH = 32,
    parameter int K_WIDTH   = 16
) (
    input logic                     clk,
    input logic                     reset,
    systolic_matmul_engine_if.slave bus
);

    localparam int FLUSH_LAST = flush_cycles(N) - 1;
    localparam int FC_W       = $clog2(flush_cycles(N));
    localparam int RW         = $clog2(N);

    state_e             state_q, state_d;
    logic [K_WIDTH-1:0] k_len_q, k_len_d;
    logic [K_WIDTH-1:0] k_cnt_q, k_cnt_d;
    logic               signed_q, signed_d;
    logic [FC_W-1:0]    flush_cnt_q, flush_cnt_d;
    logic [RW-1:0]      row_q, row_d;

    logic accept, arr_en, arr_clr;

    assign accept  = (state_q == LOAD) && bus.in_valid;
    assign arr_en  = accept || (state_q == FLUSH);
    assign arr_clr = (state_q == IDLE) && bus.start;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            k_len_q     <= '0;
            k_cnt_q     <= '0;
            signed_q    <= 1'b0;
            flush_cnt_q <= '0;
            row_q       <= '0;
        end else begin
            state_q     <= state_d;
            k_len_q     <= k_len_d;
            k_cnt_q     <= k_cnt_d;
            signed_q    <= signed_d;
            flush_cnt_q <= flush_cnt_d;
            row_q       <= row_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        k_len_d     = k_len_q;
        k_cnt_d     = k_cnt_q;
        signed_d    = signed_q;
        flush_cnt_d = flush_cnt_q;
        row_d       = row_q;
        bus.done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    k_len_d     = bus.k_len;
                    signed_d    = bus.signed_mode;
                    k_cnt_d     = '0;
                    flush_cnt_d = '0;
                    row_d       = '0;
                    state_d     = (bus.k_len == '0) ? DRAIN : LOAD;
                end
            end
            LOAD: begin
                if (accept) begin
                    k_cnt_d = k_cnt_q + K_WIDTH'(1);
                    if (k_cnt_q + K_WIDTH'(1) == k_len_q) begin
                        state_d     = FLUSH;
                        flush_cnt_d = '0;
                    end
                end
            end
            FLUSH: begin
                if (flush_cnt_q == FC_W'(FLUSH_LAST)) begin
                    state_d = DRAIN;
                end else begin
                    flush_cnt_d = flush_cnt_q + FC_W'(1);
                end
            end
            DRAIN: begin
                if (bus.out_ready) begin
                    if (row_q == RW'(N - 1)) begin
                        bus.done = 1'b1;
                        row_d    = '0;
                        state_d  = IDLE;
                    end else begin
                        row_d = row_q + RW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.in_ready    = (state_q == LOAD);
    assign bus.busy        = (state_q != IDLE);
    assign bus.out_valid   = (state_q == DRAIN);
    assign bus.out_row_idx = row_q;
    assign bus.dbg_state   = state_q;

    // Skewed operand entry points: lane i sees its stream i enabled edges late.
    logic [OP_WIDTH-1:0] a_sk [N];
    logic [OP_WIDTH-1:0] b_sk [N];

    for (genvar i = 0; i < N; i++) begin : g_skew
        logic [OP_WIDTH-1:0] a_in, b_in;
        assign a_in = (state_q == LOAD) ? bus.a_col[i*OP_WIDTH +: OP_WIDTH] : '0;
        assign b_in = (state_q == LOAD) ? bus.b_row[i*OP_WIDTH +: OP_WIDTH] : '0;

        if (i == 0) begin : g_direct
            assign a_sk[i] = a_in;
            assign b_sk[i] = b_in;
        end else begin : g_regs
            logic [OP_WIDTH-1:0] a_sr_q [i];
            logic [OP_WIDTH-1:0] b_sr_q [i];

            always_ff @(posedge clk) begin
                if (reset || arr_clr) begin
                    for (int s = 0; s < i; s++) begin
                        a_sr_q[s] <= '0;
                        b_sr_q[s] <= '0;
                    end
                end else if (arr_en) begin
                    a_sr_q[0] <= a_in;
                    b_sr_q[0] <= b_in;
                    for (int s = 1; s < i; s++) begin
                        a_sr_q[s] <= a_sr_q[s-1];
                        b_sr_q[s] <= b_sr_q[s-1];
                    end
                end
            end

            assign a_sk[i] = a_sr_q[i-1];
            assign b_sk[i] = b_sr_q[i-1];
        end
    end

    // A moves right along rows, B moves down columns; the extra edge slot receives the last PE's output.
    logic [OP_WIDTH-1:0]  a_h [N][N+1];
    logic [OP_WIDTH-1:0]  b_v [N+1][N];
    logic [ACC_WIDTH-1:0] acc [N][N];

    for (genvar i = 0; i < N; i++) begin : g_row
        assign a_h[i][0] = a_sk[i];
        assign b_v[0][i] = b_sk[i];
        for (genvar j = 0; j < N; j++) begin : g_col
            mac_pe #(
                .OP_WIDTH  (OP_WIDTH),
                .ACC_WIDTH (ACC_WIDTH)
            ) u_pe (
                .clk      (clk),
                .reset    (reset),
                .en_i     (arr_en),
                .clr_i    (arr_clr),
                .signed_i (signed_q),
                .a_i      (a_h[i][j]),
                .b_i      (b_v[i][j]),
                .a_o      (a_h[i][j+1]),
                .b_o      (b_v[i+1][j]),
                .acc_o    (acc[i][j])
            );
        end
    end

    always_comb begin
        bus.out_row = '0;
        if (state_q == DRAIN) begin
            for (int j = 0; j < N; j++) begin
                bus.out_row[j*ACC_WIDTH +: ACC_WIDTH] = acc[row_q][j];
            end
        end
    end

endmodule

// File: tb/tb_systolic_matmul_engine.sv
// Self-checking bench for systolic_matmul_engine (N=4): table-driven uniform jobs,
// hand-written corner sequences and random jobs scored against a plain matrix-product model.
module tb_systolic_matmul_engine;
  import systolic_pkg::*;

  localparam int N    = 4;
  localparam int OPW  = 8;
  localparam int ACCW = 32;
  localparam int KW   = 16;
  localparam int KMAX = 16;
  localparam int RW   = N * ACCW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  systolic_matmul_engine_if #(.N(N), .OP_WIDTH(OPW), .ACC_WIDTH(ACCW), .K_WIDTH(KW)) bus ();
  systolic_matmul_engine_if #(.N(N), .OP_WIDTH(OPW), .ACC_WIDTH(16), .K_WIDTH(KW)) bus16 ();

  systolic_matmul_engine #(.N(N), .OP_WIDTH(OPW), .ACC_WIDTH(ACCW), .K_WIDTH(KW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  systolic_matmul_engine #(.N(N), .OP_WIDTH(OPW), .ACC_WIDTH(16), .K_WIDTH(KW)) dut16 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus16)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [RW-1:0] exp_q[$];
  logic [OPW-1:0] a_m [N][KMAX];
  logic [OPW-1:0] b_m [KMAX][N];

  typedef struct {
    int          k;
    logic        sgn;
    int          bub;
    logic [7:0]  a_fill;
    logic [7:0]  b_fill;
    logic [31:0] elem;
  } vec_t;
  vec_t vecs[7];

  task automatic check(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic longint opv(input logic [7:0] x, input logic sgn);
    return sgn ? longint'($signed(x)) : longint'(x);
  endfunction

  task automatic model_push(input int k, input logic sgn);
    logic [RW-1:0] row;
    longint s;
    for (int r = 0; r < N; r++) begin
      row = '0;
      for (int j = 0; j < N; j++) begin
        s = 0;
        for (int kk = 0; kk < k; kk++) s += opv(a_m[r][kk], sgn) * opv(b_m[kk][j], sgn);
        row[j*ACCW +: ACCW] = s[31:0];
      end
      exp_q.push_back(row);
    end
  endtask

  function automatic logic [RW-1:0] rep_row(input logic [31:0] v);
    logic [RW-1:0] row;
    for (int j = 0; j < N; j++) row[j*ACCW +: ACCW] = v;
    return row;
  endfunction

  task automatic fill_uniform(input logic [7:0] a, input logic [7:0] b);
    for (int i = 0; i < N; i++)
      for (int kk = 0; kk < KMAX; kk++) begin
        a_m[i][kk] = a;
        b_m[kk][i] = b;
      end
  endtask

  task automatic fill_random();
    for (int i = 0; i < N; i++)
      for (int kk = 0; kk < KMAX; kk++) begin
        a_m[i][kk] = OPW'($urandom);
        b_m[kk][i] = OPW'($urandom);
      end
  endtask

  // ---------------- driver: one full job ----------------
  // bub_mode: 0 none, 1 toggle, 2 random; stall_mode: 0 none, 1 random, 2 row 1 held for 5 cycles
  task automatic run_job(input int k, input logic sgn, input int bub_mode, input int stall_mode,
                         input bit chk_lat);
    int beat, rows, cyc, first_ov, stall_cnt, last_edge;
    logic bub, exp_ov, hs;
    @(negedge clk);
    bus.start = 1'b1;
    bus.k_len = KW'(k);
    bus.signed_mode = sgn;
    @(negedge clk);
    bus.start = 1'b0;
    bus.k_len = '1;
    bus.signed_mode = ~sgn;
    beat = 0; rows = 0; cyc = 1; first_ov = -1; stall_cnt = 0; last_edge = -1;
    for (int t = 0; t < 3000 && rows < N; t++) begin
      exp_ov = (k == 0) || (last_edge >= 0 && cyc >= last_edge + 2 * N - 1);
      if (bus.out_valid && first_ov < 0) first_ov = cyc;
      check_int("in_ready", int'(bus.in_ready), int'(beat < k));
      check_int("busy", int'(bus.busy), 1);
      check_int("out_valid", int'(bus.out_valid), int'(exp_ov));
      case (bub_mode)
        0:       bub = 1'b0;
        1:       bub = t[0];
        default: bub = ($urandom_range(0, 3) == 0);
      endcase
      bus.in_valid = !bub;
      for (int i = 0; i < N; i++) begin
        if (beat < k) begin
          bus.a_col[i*OPW +: OPW] = a_m[i][beat];
          bus.b_row[i*OPW +: OPW] = b_m[beat][i];
        end else begin
          bus.a_col[i*OPW +: OPW] = OPW'($urandom);
          bus.b_row[i*OPW +: OPW] = OPW'($urandom);
        end
      end
      if (bus.in_valid && beat < k) begin
        beat++;
        if (beat == k) last_edge = cyc + 1;
      end
      case (stall_mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = ($urandom_range(0, 1) == 1);
        default: bus.out_ready = !(rows == 1 && stall_cnt < 5);
      endcase
      #1;
      hs = exp_ov && bus.out_ready;
      check_int("done", int'(bus.done), int'(hs && rows == N - 1));
      if (exp_ov) begin
        check_int("row_idx", int'(bus.out_row_idx), rows);
        if (exp_q.size() > 0) check("out_row", bus.out_row, exp_q[0]);
        if (!bus.out_ready && rows == 1) stall_cnt++;
      end
      if (hs) begin
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        rows++;
      end
      @(negedge clk);
      cyc++;
    end
    check_int("rows_delivered", rows, N);
    if (chk_lat) check_int("latency", first_ov, (k == 0) ? 1 : 1 + k + 2 * N - 1);
    if (stall_mode == 2) check_int("stall_cycles", stall_cnt, 5);
    check_int("post_out_valid", int'(bus.out_valid), 0);
    check_int("post_busy", int'(bus.busy), 0);
    check_int("post_done", int'(bus.done), 0);
    check_int("post_state", int'(bus.dbg_state), int'(IDLE));
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    exp_q.delete();
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int rows16;
    vecs[0] = '{k: 3,  sgn: 1'b1, bub: 1, a_fill: 8'hFF, b_fill: 8'hFE, elem: 32'd6};
    vecs[1] = '{k: 3,  sgn: 1'b0, bub: 1, a_fill: 8'hFF, b_fill: 8'hFE, elem: 32'd194310};
    vecs[2] = '{k: 0,  sgn: 1'b0, bub: 0, a_fill: 8'hAA, b_fill: 8'h55, elem: 32'd0};
    vecs[3] = '{k: 1,  sgn: 1'b0, bub: 0, a_fill: 8'h03, b_fill: 8'h05, elem: 32'd15};
    vecs[4] = '{k: 5,  sgn: 1'b1, bub: 2, a_fill: 8'h80, b_fill: 8'h7F, elem: 32'hFFFE_C280};
    vecs[5] = '{k: 2,  sgn: 1'b1, bub: 0, a_fill: 8'h80, b_fill: 8'h80, elem: 32'd32768};
    vecs[6] = '{k: 16, sgn: 1'b0, bub: 0, a_fill: 8'hFF, b_fill: 8'hFF, elem: 32'd1040400};

    bus.start = 0; bus.signed_mode = 0; bus.k_len = '0; bus.in_valid = 0;
    bus.a_col = '0; bus.b_row = '0; bus.out_ready = 0;
    bus16.start = 0; bus16.signed_mode = 0; bus16.k_len = '0; bus16.in_valid = 0;
    bus16.a_col = '0; bus16.b_row = '0; bus16.out_ready = 0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_int("rst_in_ready", int'(bus.in_ready), 0);
    check_int("rst_busy", int'(bus.busy), 0);
    check_int("rst_out_valid", int'(bus.out_valid), 0);
    check_int("rst_done", int'(bus.done), 0);
    check("rst_out_row", bus.out_row, '0);
    check_int("rst_row_idx", int'(bus.out_row_idx), 0);
    check_int("rst_state", int'(bus.dbg_state), int'(IDLE));
    reset = 1'b0;

    // identity: rows of C equal rows of B
    for (int i = 0; i < N; i++)
      for (int kk = 0; kk < N; kk++) begin
        a_m[i][kk] = (i == kk) ? 8'd1 : 8'd0;
        b_m[kk][i] = OPW'(4 * kk + i + 1);
      end
    for (int r = 0; r < N; r++) begin
      logic [RW-1:0] row;
      for (int j = 0; j < N; j++) row[j*ACCW +: ACCW] = ACCW'(4 * r + j + 1);
      exp_q.push_back(row);
    end
    run_job(4, 1'b0, 0, 0, 1'b1);

    // uniform-fill table
    for (int v = 0; v < 7; v++) begin
      fill_uniform(vecs[v].a_fill, vecs[v].b_fill);
      for (int r = 0; r < N; r++) exp_q.push_back(rep_row(vecs[v].elem));
      run_job(vecs[v].k, vecs[v].sgn, vecs[v].bub, 0, vecs[v].bub == 0);
    end

    // backpressure on row 1
    fill_random();
    model_push(4, 1'b0);
    run_job(4, 1'b0, 0, 2, 1'b1);

    // reset in the middle of LOAD, then a clean small job
    fill_random();
    @(negedge clk);
    bus.start = 1'b1; bus.k_len = KW'(4); bus.signed_mode = 1'b0;
    @(negedge clk);
    bus.start = 1'b0; bus.in_valid = 1'b1;
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < N; i++) begin
        bus.a_col[i*OPW +: OPW] = a_m[i][b];
        bus.b_row[i*OPW +: OPW] = b_m[b][i];
      end
      @(negedge clk);
    end
    check_int("midload_in_ready", int'(bus.in_ready), 1);
    reset = 1'b1; bus.in_valid = 1'b0;
    #1;
    check_int("abort_no_done", int'(bus.done), 0);
    @(negedge clk);
    reset = 1'b0;
    check_int("abort_in_ready", int'(bus.in_ready), 0);
    check_int("abort_busy", int'(bus.busy), 0);
    check_int("abort_out_valid", int'(bus.out_valid), 0);
    check_int("abort_done", int'(bus.done), 0);
    check("abort_out_row", bus.out_row, '0);
    fill_uniform(8'd3, 8'd5);
    for (int r = 0; r < N; r++) exp_q.push_back(rep_row(32'd15));
    run_job(1, 1'b0, 0, 0, 1'b1);

    // random jobs against the model
    for (int n = 0; n < 6; n++) begin
      int k;
      logic sgn;
      k = $urandom_range(1, 10);
      sgn = 1'($urandom_range(0, 1));
      fill_random();
      model_push(k, sgn);
      run_job(k, sgn, 2, 1, 1'b0);
    end

    // 16-bit accumulator wrap: 2 * 255 * 255 = 130050 -> 64514
    @(negedge clk);
    bus16.start = 1'b1; bus16.k_len = KW'(2); bus16.signed_mode = 1'b0;
    bus16.a_col = '1; bus16.b_row = '1; bus16.in_valid = 1'b1; bus16.out_ready = 1'b1;
    @(negedge clk);
    bus16.start = 1'b0;
    rows16 = 0;
    for (int t = 0; t < 200 && rows16 < N; t++) begin
      #1;
      if (bus16.out_valid) begin
        check("wrap_row", RW'(bus16.out_row), RW'({4{16'd64514}}));
        check_int("wrap_idx", int'(bus16.out_row_idx), rows16);
        check_int("wrap_done", int'(bus16.done), int'(rows16 == N - 1));
        rows16++;
      end
      @(negedge clk);
    end
    check_int("wrap_rows", rows16, N);
    check_int("wrap_idle", int'(bus16.busy), 0);
    bus16.in_valid = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/systolic_matmul_engine.md
Name: systolic_matmul_engine

Overview:
- Output-stationary N×N systolic matrix-multiply engine. Computes C = A·B, where A is N×K and B is K×N.
- K is set at run time. Operand skewing is done internally.
- Operands stream in one k-slice per beat over a valid/ready handshake. The block runs a start/done job FSM and drains C one row per beat over a valid/ready output.
- Sits between the operand buffers and the result writeback, in the same clock domain.

Parameters:
- N, 16, array dimension (rows = columns).
- OP_WIDTH, 8, operand width.
- ACC_WIDTH, 32, accumulator width.
- K_WIDTH, 16, width of the run-time K length.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- start  in  1  job start; sampled in IDLE only.
- signed_mode  in  1  1 = two's-complement operands, 0 = unsigned; latched on start.
- k_len  in  K_WIDTH  number of k-slices; latched on start.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  operand beat accepted when in_valid && in_ready.
- a_col  in  N*OP_WIDTH  A[i][k] in lane i.
- b_row  in  N*OP_WIDTH  B[k][j] in lane j.
- busy  out  1  high in any state except IDLE.
- out_valid  out  1  result row valid.
- out_ready  in  1  downstream accept.
- out_row  out  N*ACC_WIDTH  C[r][j] in lane j.
- out_row_idx  out  $clog2(N)  row index r.
- done  out  1  one-cycle pulse on the final row handshake.

Behaviour:
- Reset: state IDLE; all skew, operand and accumulator registers are 0. in_ready, busy, out_valid, done = 0. out_row = 0, out_row_idx = 0.
- IDLE:
  - start=1 latches k_len and signed_mode, clears all accumulators and skew/operand registers at that edge, and sets k_cnt = 0.
  - If k_len != 0, next state is LOAD.
  - If k_len = 0, next state is DRAIN; all rows read 0.
- LOAD:
  - in_ready = 1.
  - Each accepted beat advances the whole array one step (global enable) and increments k_cnt.
  - When k_cnt reaches k_len, go to FLUSH; in_ready drops in the cycle after the last accepted beat.
  - A cycle with no accepted beat freezes the array (bubble-safe).
- FLUSH:
  - Array enabled every cycle with zero operands injected, for exactly FLUSH_CYCLES = 2N-1 cycles (counter), then go to DRAIN.
- Pipeline:
  - Lane i of A is delayed by i skew registers, then enters operand column 0 and shifts one PE right per enabled cycle.
  - B is the same with lane j moving downward.
  - PE(i,j) accumulates the operand pair held in its registers on the next enabled edge.
  - The last beat therefore reaches PE(N-1,N-1)'s accumulator after 2N-1 enabled edges.
- Arithmetic:
  - Product is 2*OP_WIDTH wide, sign- or zero-extended per the latched signed_mode, then added to ACC_WIDTH.
  - Overflow wraps modulo 2^ACC_WIDTH; no saturation.
- DRAIN:
  - out_valid = 1; out_row = row r of the accumulators; out_row_idx = r, starting at 0.
  - On out_valid && out_ready, r increments.
  - While out_ready = 0, out_row and out_row_idx hold stable.
  - On the handshake with r = N-1: done pulses 1 cycle, go to IDLE, out_valid drops next cycle.
- start while busy is ignored. in_valid outside LOAD is ignored.
- Accumulators keep their values in IDLE until the next start.
- Reset at any point, including mid-LOAD or mid-DRAIN, aborts the job and restores reset values on the next edge. No done pulse is produced.
- Job latency with no stalls: 1 + k_len + (2N-1) cycles from the start edge to the first out_valid.

Decomposition:
- Package systolic_pkg holds:
  - the state enum (IDLE, LOAD, FLUSH, DRAIN);
  - the FLUSH_CYCLES function of N;
  - the product-extension helper function.
- Sub-module mac_pe, one per array position:
  - operand registers A/B with pass-through outputs;
  - ports: enable, synchronous clear, signed_mode, accumulator.
- The engine holds the FSM, counters, skew registers and output mux.

Test Plan (N=4, OP_WIDTH=8, ACC_WIDTH=32 unless stated):
- Identity: unsigned, k_len=4, A=I, B[k][j]=4k+j+1, no stalls -> rows 0..3 equal B rows, e.g. row 2 = {9,10,11,12}. done pulses once, first out_valid 12 cycles after start.
- Signed with bubbles: signed_mode=1, k_len=3, all A=-1, all B=-2, in_valid toggling 1/0 -> every C element = 6. With signed_mode=0 the same bytes give every element = 3·255·254 = 194310.
- Backpressure: out_ready low for 5 cycles on row 1 -> out_row and out_row_idx stable for all 5 cycles, rows still delivered in order 0..3, then done.
- Wrap-around: ACC_WIDTH=16, unsigned, k_len=2, all operands 255 -> each element = 130050 mod 65536 = 64514.
- k_len=0 -> no in_ready. DRAIN starts the cycle after start; 4 zero rows, then done.
- Reset mid-LOAD after 2 beats, then a new job with k_len=1, a_col=all 3, b_row=all 5 -> all outputs 15, with no residue from the aborted job.
